// File: rtl/id_seq_ctrl_pkg.sv
// Shared types and helpers for the ID digit sequencer: state encoding,
// count width and the wrap-aware advance function.
package id_seq_ctrl_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Returns {wrap, next_count}; bounded explicitly so count never leaves 0..last.
    function automatic logic [CNT_W:0] advance(
        input logic [CNT_W-1:0] cur,
        input logic             down,
        input logic [CNT_W-1:0] last
    );
        logic [CNT_W:0] res;
        if (down) begin
            if (cur == {CNT_W{1'b0}}) begin
                res = {1'b1, last};
            end else if (cur > last) begin
                res = {1'b0, last};
            end else begin
                res = {1'b0, cur - CNT_W'(1)};
            end
        end else begin
            if (cur >= last) begin
                res = {1'b1, {CNT_W{1'b0}}};
            end else begin
                res = {1'b0, cur + CNT_W'(1)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/id_seq_ctrl_edge_det.sv
// Registered rising-edge detector. The first clock after reset only captures
// the input level, so a line already high at reset release never fires.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_r;
    logic armed_r;

    // Previous-sample and arming registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r  <= d;
            armed_r <= 1'b1;
        end
    end

    assign rise = armed_r & d & ~prev_r;

endmodule

// File: rtl/id_seq_ctrl.sv
// Digit-ROM address sequencer: IDLE/RUN/PAUSE control with a prescaled
// automatic advance, single-step, up/down direction and a wrap pulse.
module id_seq_ctrl
    import id_seq_ctrl_pkg::*;
#(
    parameter int DIV_MAX = 50000000,
    parameter int LAST    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             wrap
);

    localparam int                PW     = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [PW-1:0]     PRE_TOP = PW'(DIV_MAX - 1);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(LAST);

    state_t           state_r, state_n;
    logic [CNT_W-1:0] count_r, count_n;
    logic [PW-1:0]    pre_r, pre_n;
    logic             wrap_r, wrap_n;
    logic             running_r;
    logic             start_ev, stop_ev, step_ev;
    logic [CNT_W:0]   adv_s;

    edge_det u_start_det (.clk(clk), .rst_n(rst_n), .d(start), .rise(start_ev));
    edge_det u_stop_det  (.clk(clk), .rst_n(rst_n), .d(stop),  .rise(stop_ev));
    edge_det u_step_det  (.clk(clk), .rst_n(rst_n), .d(step),  .rise(step_ev));

    assign adv_s = advance(count_r, dir, LAST_C);

    // Next-state logic; priority clr > stop > start > step, only the winner acts.
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        pre_n   = pre_r;
        wrap_n  = 1'b0;
        if (clr) begin
            state_n = ST_IDLE;
            count_n = {CNT_W{1'b0}};
            pre_n   = {PW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_n = {CNT_W{1'b0}};
                    pre_n   = {PW{1'b0}};
                    if (stop_ev) begin
                        state_n = ST_IDLE;
                    end else if (start_ev) begin
                        state_n = ST_RUN;
                    end else if (step_ev) begin
                        count_n = adv_s[CNT_W-1:0];
                        wrap_n  = adv_s[CNT_W];
                        state_n = ST_PAUSE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A stop freezes the prescaler so a resume finishes the partial period.
                    if (stop_ev) begin
                        state_n = ST_PAUSE;
                    end else if (pre_r >= PRE_TOP) begin
                        pre_n   = {PW{1'b0}};
                        count_n = adv_s[CNT_W-1:0];
                        wrap_n  = adv_s[CNT_W];
                    end else begin
                        pre_n = pre_r + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (stop_ev) begin
                        state_n = ST_PAUSE;
                    end else if (start_ev) begin
                        state_n = ST_RUN;
                    end else if (step_ev) begin
                        count_n = adv_s[CNT_W-1:0];
                        wrap_n  = adv_s[CNT_W];
                    end else begin
                        state_n = ST_PAUSE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    count_n = {CNT_W{1'b0}};
                    pre_n   = {PW{1'b0}};
                end
            endcase
        end
    end

    // State, count, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= {CNT_W{1'b0}};
            pre_r     <= {PW{1'b0}};
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            pre_r     <= pre_n;
            wrap_r    <= wrap_n;
            running_r <= (state_n == ST_RUN);
        end
    end

    assign count   = count_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_id_seq_ctrl.sv
// Self-checking bench for id_seq_ctrl (DIV_MAX=4, LAST=5): vector table,
// directed multi-cycle sequences and randomized traffic against a mode model.
module tb_id_seq_ctrl;

    localparam int DIV  = 4;
    localparam int LAST = 5;

    logic       clk = 1'b0;
    logic       rst_n, clr, start, stop, step, dir;
    logic [2:0] count;
    logic       running, wrap;

    int checks   = 0;
    int failures = 0;

    id_seq_ctrl #(.DIV_MAX(DIV), .LAST(LAST)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .stop(stop),
        .step(step), .dir(dir), .count(count), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference model: run/pause flags, digit value and position within the period.
    bit m_run, m_pause, m_wrap, m_armed;
    bit p_start, p_stop, p_step;
    int m_cnt, m_pre;

    task automatic model_reset();
        m_run = 0; m_pause = 0; m_wrap = 0; m_armed = 0;
        p_start = 0; p_stop = 0; p_step = 0;
        m_cnt = 0; m_pre = 0;
    endtask

    task automatic model_adv();
        if (dir) begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + LAST) % (LAST + 1);
        end else begin
            m_cnt  = (m_cnt + 1) % (LAST + 1);
            m_wrap = (m_cnt == 0);
        end
    endtask

    task automatic model_edge();
        bit es, ep, et;
        es = m_armed && start && !p_start;
        ep = m_armed && stop  && !p_stop;
        et = m_armed && step  && !p_step;
        m_wrap = 0;
        if (clr) begin
            m_run = 0; m_pause = 0; m_cnt = 0; m_pre = 0;
        end else if (m_run) begin
            if (ep) begin
                m_run = 0; m_pause = 1;
            end else begin
                m_pre = m_pre + 1;
                if (m_pre == DIV) begin
                    m_pre = 0;
                    model_adv();
                end
            end
        end else if (!ep) begin
            if (es) begin
                m_run = 1; m_pause = 0;
            end else if (et) begin
                model_adv();
                m_pause = 1;
            end
        end
        p_start = start; p_stop = stop; p_step = step; m_armed = 1;
    endtask

    task automatic cycle();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input int c, input bit r, input bit w);
        check({name, ".count"},   {5'd0, count},   8'(c));
        check({name, ".running"}, {7'd0, running}, {7'd0, r});
        check({name, ".wrap"},    {7'd0, wrap},    {7'd0, w});
    endtask

    task automatic set_in(input bit c, input bit s, input bit p, input bit t, input bit d);
        clr = c; start = s; stop = p; step = t; dir = d;
    endtask

    typedef struct {
        bit       clr, start, stop, step, dir;
        int       cnt;
        bit       run, wrp;
    } vec_t;

    vec_t vecs[22];

    initial begin
        vecs[0]  = '{0,1,0,0,0, 0,0,0};
        vecs[1]  = '{0,1,0,0,0, 0,0,0};
        vecs[2]  = '{0,0,0,0,0, 0,0,0};
        vecs[3]  = '{0,0,0,1,0, 1,0,0};
        vecs[4]  = '{0,0,0,1,0, 1,0,0};
        vecs[5]  = '{0,0,0,0,0, 1,0,0};
        vecs[6]  = '{0,0,0,1,1, 0,0,0};
        vecs[7]  = '{0,0,0,0,1, 0,0,0};
        vecs[8]  = '{0,0,0,1,1, 5,0,1};
        vecs[9]  = '{0,0,0,0,1, 5,0,0};
        vecs[10] = '{0,0,0,1,0, 0,0,1};
        vecs[11] = '{0,0,0,0,0, 0,0,0};
        vecs[12] = '{0,1,0,1,0, 0,1,0};
        vecs[13] = '{0,0,0,0,0, 0,1,0};
        vecs[14] = '{0,0,0,1,0, 0,1,0};
        vecs[15] = '{0,1,1,0,0, 0,0,0};
        vecs[16] = '{0,0,0,0,0, 0,0,0};
        vecs[17] = '{0,1,0,0,0, 0,1,0};
        vecs[18] = '{0,0,0,0,0, 0,1,0};
        vecs[19] = '{0,0,0,0,0, 1,1,0};
        vecs[20] = '{1,0,0,1,0, 0,0,0};
        vecs[21] = '{0,0,0,0,0, 0,0,0};

        // Reset with start already high: release must not create a start event.
        rst_n = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) cycle();
        check_outs("reset", 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            set_in(vecs[i].clr, vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].dir);
            cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].run, vecs[i].wrp);
        end

        // Full up-count lap: one advance every DIV RUN cycles, wrap on the 24th.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check_outs("lap_start", 0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            check_outs($sformatf("lap_k%0d", k), (k / DIV) % (LAST + 1), 1'b1, k == 24);
        end

        // Direction flip mid-run: down from 0 wraps to LAST after one period.
        dir = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check_outs($sformatf("down_k%0d", k), (k == 4) ? 5 : 0, 1'b1, k == 4);
        end
        repeat (8) cycle();
        check_outs("down_to3", 3, 1'b1, 1'b0);

        // clr together with step while running at count 3.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        check_outs("clr_step", 0, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_outs("clr_after", 0, 1'b0, 1'b0);

        // Asynchronous reset mid-run, observed before the next clock edge.
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        check_outs("pre_async", 1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 0, 1'b0, 1'b0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            clr   = ($urandom_range(0, 40) == 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 9) == 0);
            step  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            cycle();
            check_outs($sformatf("rand%0d", i), m_cnt, m_run, m_wrap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
